// File: rtl/sparse_pkg.sv
// Shared widths and the compressed 2:4 packet layout used by the encoder and the sparse PEs.
package sparse_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned IDX_WIDTH  = 2;
    localparam int unsigned NUM_ELEM   = 4;
    localparam int unsigned MAG_WIDTH  = DATA_WIDTH + 1;

    // Bit layout: val_0[19:12], val_1[11:4], idx_0[3:2], idx_1[1:0].
    typedef struct packed {
        logic [DATA_WIDTH-1:0] val_0;
        logic [DATA_WIDTH-1:0] val_1;
        logic [IDX_WIDTH-1:0]  idx_0;
        logic [IDX_WIDTH-1:0]  idx_1;
    } sparse_packet_t;

endpackage

// File: rtl/sparse_weight_encoder.sv
// 2:4 sparse compressor: keeps the two largest-magnitude INT8 elements of each dense row,
// two-stage valid/ready pipeline with row and prune statistics counters.
module sparse_weight_encoder
    import sparse_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output sparse_packet_t                 out_pkt,
    input  logic                           cnt_clr,
    output logic [CNT_WIDTH-1:0]           row_cnt,
    output logic [CNT_WIDTH-1:0]           prune_cnt
);

    localparam int unsigned NZ_WIDTH = $clog2(NUM_ELEM + 1);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_val [NUM_ELEM];
    logic [MAG_WIDTH-1:0]  s1_mag [NUM_ELEM];

    logic [DATA_WIDTH-1:0] in_elem [NUM_ELEM];
    logic [MAG_WIDTH-1:0]  in_mag  [NUM_ELEM];
    logic [NZ_WIDTH-1:0]   in_nz;

    logic [IDX_WIDTH-1:0]  rank [NUM_ELEM];
    logic [NUM_ELEM-1:0]   keep;
    logic                  have_first;
    sparse_packet_t        sel_pkt;

    logic stage_adv;
    logic in_hs;
    logic out_hs;

    assign stage_adv = !out_valid || out_ready;
    assign in_ready  = !s1_valid || stage_adv;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Unpack row, one extra magnitude bit so -128 ranks above 127.
    always_comb begin
        in_nz = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            in_elem[k] = in_row[k*DATA_WIDTH +: DATA_WIDTH];
            in_mag[k]  = in_elem[k][DATA_WIDTH-1] ? (~{1'b1, in_elem[k]} + MAG_WIDTH'(1))
                                                  : {1'b0, in_elem[k]};
            in_nz      = in_nz + NZ_WIDTH'(in_elem[k] != '0);
        end
    end

    // Rank = number of elements that beat this one; ties go to the lower index.
    always_comb begin
        sel_pkt    = '0;
        have_first = 1'b0;
        keep       = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_ELEM; j++) begin
                if (j != i) begin
                    if ((s1_mag[j] > s1_mag[i]) || ((s1_mag[j] == s1_mag[i]) && (j < i))) begin
                        rank[i] = rank[i] + IDX_WIDTH'(1);
                    end
                end
            end
            keep[i] = (rank[i] < IDX_WIDTH'(2));
        end
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (keep[i]) begin
                if (!have_first) begin
                    sel_pkt.idx_0 = IDX_WIDTH'(i);
                    sel_pkt.val_0 = s1_val[i];
                    have_first    = 1'b1;
                end else begin
                    sel_pkt.idx_1 = IDX_WIDTH'(i);
                    sel_pkt.val_1 = s1_val[i];
                end
            end
        end
    end

    // Stage 1: captured row and magnitudes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NUM_ELEM; k++) begin
                s1_val[k] <= '0;
                s1_mag[k] <= '0;
            end
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < NUM_ELEM; k++) begin
                    s1_val[k] <= in_elem[k];
                    s1_mag[k] <= in_mag[k];
                end
            end
        end
    end

    // Stage 2: registered packet, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pkt   <= '0;
        end else if (stage_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pkt <= sel_pkt;
            end
        end
    end

    // Statistics; clear wins over any same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            prune_cnt <= '0;
        end else if (cnt_clr) begin
            row_cnt   <= '0;
            prune_cnt <= '0;
        end else begin
            if (out_hs) begin
                row_cnt <= row_cnt + CNT_WIDTH'(1);
            end
            if (in_hs && (in_nz > NZ_WIDTH'(2)) && (prune_cnt != '1)) begin
                prune_cnt <= prune_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
